qracc_output_packer: RTL and testbench

//  Downstream of seq_acc. Captures one MAC output vector (outputElements x outputBits) via valid/ready.

---
 rtl/qracc_output_packer_if.sv | 18 +
 rtl/qracc_output_packer.sv | 77 +++++++
 tb/tb_qracc_output_packer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qracc_output_packer_if.sv
// qracc_output_packer_if: MAC-vector input and write-beat output handshake bundle for qracc_output_packer
//   master: packer side (accepts mac vector, drives write beats)
//   slave : environment side (offers mac vector, accepts write beats)
interface qracc_output_packer_if #(
  parameter int data_width = 256,
  parameter int beat_width = 32,
  parameter int addr_width = 32
);
  logic                  mac_valid;
  logic                  mac_ready;
  logic [data_width-1:0] mac_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [beat_width-1:0] wr_data;
  logic [addr_width-1:0] wr_addr;
  modport master (input mac_valid, mac_data, wr_ready, output mac_ready, wr_valid, wr_data, wr_addr);
  modport slave (output mac_valid, mac_data, wr_ready, input mac_ready, wr_valid, wr_data, wr_addr);
endinterface

// File: rtl/qracc_output_packer.sv
// qracc_output_packer: captures one MAC output vector and writes it as beats to a wrapping buffer region
//   clk, rst_n     : clock, async active-low reset
//   start          : pulse; clears pointer and vector count, aborts the vector in flight
//   base_addr      : region base byte address
//   region_words   : region size in beats, 0 = no wrap
//   bus            : mac vector valid/ready in, write beat valid/ready out
//   busy           : a vector is held and draining
//   vec_count      : vectors fully written since start/reset
module qracc_output_packer #(
  parameter int output_bits     = 8,
  parameter int output_elements = 32,
  parameter int interface_width = 32,
  parameter int addr_width      = 32,
  parameter int cnt_width       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width-1:0] region_words,
  qracc_output_packer_if.master bus,
  output logic                  busy,
  output logic [cnt_width-1:0]  vec_count
);
  localparam int beats = output_elements * output_bits / interface_width;
  localparam int bpb = interface_width / 8;
  localparam int bw = beats > 1 ? $clog2(beats) : 1;
  typedef enum logic {EMPTY, DRAIN} state_t;
  state_t                                state;
  logic                                  run;
  logic [bw-1:0]                         beat;
  logic [addr_width-1:0]                 ptr;
  logic [beats-1:0][interface_width-1:0] vec;
  logic [addr_width-1:0]                 ptr_inc;
  logic                                  drain;
  // run holds mac_ready low while reset is asserted even though state already reads EMPTY
  always_comb begin
    drain = state == DRAIN;
    ptr_inc = ptr + 1'b1;
    bus.mac_ready = run && !drain && !start;
    bus.wr_valid = drain;
    bus.wr_data = drain ? vec[beat] : '0;
    bus.wr_addr = drain ? base_addr + addr_width'(ptr * addr_width'(bpb)) : '0;
    busy = drain;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      run <= 1'b0;
      beat <= '0;
      ptr <= '0;
      vec <= '0;
      vec_count <= '0;
    end else begin
      run <= 1'b1;
      if (start) begin
        state <= EMPTY;
        beat <= '0;
        ptr <= '0;
        vec_count <= '0;
      end else if (!drain) begin
        if (bus.mac_valid && run) begin
          vec <= bus.mac_data;
          beat <= '0;
          state <= DRAIN;
        end
      end else if (bus.wr_ready) begin
        beat <= beat + 1'b1;
        ptr <= (region_words != '0 && ptr_inc == region_words) ? '0 : ptr_inc;
        if (beat == bw'(beats - 1)) begin
          vec_count <= vec_count + 1'b1;
          state <= EMPTY;
        end
      end
    end
  end
endmodule

// File: tb/tb_qracc_output_packer.sv
// tb_qracc_output_packer: directed self-checking bench for qracc_output_packer
module tb_qracc_output_packer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [31:0] base_addr = 32'h100;
  logic [31:0] region_words = 0;
  logic        busy;
  logic [15:0] vec_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int acc_cyc[$];
  int unstable, first_beat, last_beat;

  qracc_output_packer_if #(.data_width(256), .beat_width(32), .addr_width(32)) bus ();

  qracc_output_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .region_words(region_words), .bus(bus), .busy(busy), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] vec_of(int v);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = 8'(k + 64 * v);
    return r;
  endfunction

  function automatic logic [31:0] beat_of(int i);
    int v, b;
    v = i / 8;
    b = i % 8;
    return {8'(4*b + 3 + 64*v), 8'(4*b + 2 + 64*v), 8'(4*b + 1 + 64*v), 8'(4*b + 64*v)};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic collect(input int nvec, input bit stall);
    int acc, beats, st, cyc;
    logic [31:0] pd, pa;
    bit pv;
    acc = 0; beats = 0; st = 0; cyc = 0; pv = 0; pd = 0; pa = 0;
    unstable = 0; first_beat = -1; last_beat = -1;
    q_addr.delete(); q_data.delete(); acc_cyc.delete();
    while (cyc < 300 && beats < nvec * 8) begin
      @(negedge clk);
      cyc++;
      bus.mac_valid = acc < nvec;
      bus.mac_data = vec_of(acc);
      if (pv && (bus.wr_data !== pd || bus.wr_addr !== pa)) unstable++;
      bus.wr_ready = !(stall && bus.wr_valid && (beats % 8 == 2 || beats % 8 == 5) && st < 3);
      pv = bus.wr_valid && !bus.wr_ready;
      pd = bus.wr_data;
      pa = bus.wr_addr;
      if (pv) st++;
      if (bus.wr_valid && bus.wr_ready) begin
        q_addr.push_back(bus.wr_addr);
        q_data.push_back(bus.wr_data);
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
        st = 0;
      end
      if (bus.mac_valid && bus.mac_ready) begin
        acc_cyc.push_back(cyc);
        acc++;
      end
    end
    bus.mac_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.mac_ready, bus.wr_valid, busy} !== 3'b000 || bus.wr_data !== 0 || bus.wr_addr !== 0 || vec_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ready/valid/busy=%b data=%h addr=%h cnt=%0d, want all 0", {bus.mac_ready, bus.wr_valid, busy}, bus.wr_data, bus.wr_addr, vec_count);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bus.mac_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.mac_ready);
    end
  endtask

  task automatic test_single();
    pulse_start();
    collect(1, 0);
    checks++;
    if (q_data.size() !== 8) begin
      errors++;
      $display("FAIL single_beats: got %0d want 8", q_data.size());
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== beat_of(i) || q_addr[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL single_beat%0d: data=%h addr=%h want data=%h addr=%h", i, q_data[i], q_addr[i], beat_of(i), 32'h100 + 32'(4 * i));
      end
    end
    checks++;
    if (q_data.size() == 8 && (q_data[0] !== 32'h03020100 || q_data[7] !== 32'h1F1E1D1C)) begin
      errors++;
      $display("FAIL single_ends: beat0=%h beat7=%h want 03020100 1F1E1D1C", q_data[0], q_data[7]);
    end
    checks++;
    if (last_beat - first_beat + 1 !== 8) begin
      errors++;
      $display("FAIL single_span: got %0d want 8", last_beat - first_beat + 1);
    end
    checks++;
    if (vec_count !== 16'd1 || bus.wr_valid !== 1'b0 || bus.mac_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end_state: cnt=%0d valid=%b ready=%b busy=%b want 1 0 1 0", vec_count, bus.wr_valid, bus.mac_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    collect(2, 0);
    checks++;
    if (acc_cyc.size() !== 2 || acc_cyc[1] - acc_cyc[0] !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2 9", acc_cyc.size(), acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1);
    end
    checks++;
    if (q_data.size() !== 16) begin
      errors++;
      $display("FAIL b2b_beats: got %0d want 16", q_data.size());
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== beat_of(i) || q_addr[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_beat%0d: data=%h addr=%h want data=%h addr=%h", i, q_data[i], q_addr[i], beat_of(i), 32'h100 + 32'(4 * i));
      end
    end
    checks++;
    if (vec_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", vec_count);
    end
  endtask

  task automatic test_stall();
    pulse_start();
    collect(1, 1);
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL stall_stable: changes while stalled %0d want 0", unstable);
    end
    checks++;
    if (last_beat - first_beat + 1 !== 14) begin
      errors++;
      $display("FAIL stall_span: got %0d cycles want 14", last_beat - first_beat + 1);
    end
    checks++;
    if (q_data.size() !== 8) begin
      errors++;
      $display("FAIL stall_beats: got %0d want 8", q_data.size());
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== beat_of(i) || q_addr[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL stall_beat%0d: data=%h addr=%h want data=%h addr=%h", i, q_data[i], q_addr[i], beat_of(i), 32'h100 + 32'(4 * i));
      end
    end
    checks++;
    if (vec_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_count: got %0d want 1", vec_count);
    end
  endtask

  task automatic test_wrap();
    base_addr = 0;
    region_words = 12;
    pulse_start();
    collect(2, 0);
    checks++;
    if (q_addr.size() !== 16) begin
      errors++;
      $display("FAIL wrap_beats: got %0d want 16", q_addr.size());
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== 32'(i < 12 ? 4 * i : 4 * (i - 12)) || q_data[i] !== beat_of(i)) begin
        errors++;
        $display("FAIL wrap_beat%0d: addr=%h data=%h want addr=%h data=%h", i, q_addr[i], q_data[i], 32'(i < 12 ? 4 * i : 4 * (i - 12)), beat_of(i));
      end
    end
    base_addr = 32'h100;
    region_words = 0;
  endtask

  task automatic test_start_abort();
    pulse_start();
    bus.mac_data = vec_of(0);
    bus.mac_valid = 1;
    bus.wr_ready = 1;
    @(negedge clk);
    bus.mac_valid = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 32'h110 || bus.wr_data !== beat_of(4)) begin
      errors++;
      $display("FAIL abort_beat4: valid=%b addr=%h data=%h want 1 00000110 %h", bus.wr_valid, bus.wr_addr, bus.wr_data, beat_of(4));
    end
    start = 1;
    @(negedge clk);
    checks++;
    if (bus.wr_valid !== 1'b0 || busy !== 1'b0 || vec_count !== 0 || bus.mac_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: valid=%b busy=%b cnt=%0d ready=%b want 0 0 0 0", bus.wr_valid, busy, vec_count, bus.mac_ready);
    end
    start = 0;
    collect(1, 0);
    checks++;
    if (q_addr.size() !== 8 || q_addr[0] !== 32'h100 || q_data[0] !== beat_of(0)) begin
      errors++;
      $display("FAIL abort_restart: beats=%0d addr0=%h data0=%h want 8 00000100 %h", q_addr.size(), q_addr.size() ? q_addr[0] : 32'hx, q_data.size() ? q_data[0] : 32'hx, beat_of(0));
    end
    checks++;
    if (vec_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_count: got %0d want 1", vec_count);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    bus.mac_data = vec_of(0);
    bus.mac_valid = 1;
    @(negedge clk);
    bus.mac_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got %b want 1", busy);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.mac_ready, bus.wr_valid, busy} !== 3'b000 || bus.wr_data !== 0 || bus.wr_addr !== 0 || vec_count !== 0) begin
      errors++;
      $display("FAIL rstmid_outputs: ready/valid/busy=%b data=%h addr=%h cnt=%0d want all 0", {bus.mac_ready, bus.wr_valid, busy}, bus.wr_data, bus.wr_addr, vec_count);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bus.mac_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b want 1", bus.mac_ready);
    end
    collect(1, 0);
    checks++;
    if (q_addr.size() !== 8 || q_addr[0] !== 32'h100 || vec_count !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_restart: beats=%0d addr0=%h cnt=%0d want 8 00000100 1", q_addr.size(), q_addr.size() ? q_addr[0] : 32'hx, vec_count);
    end
  endtask

  initial begin
    bus.mac_valid = 0;
    bus.mac_data = 0;
    bus.wr_ready = 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_start_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
